// File: rtl/corr_pkg.sv
// Shared constants and FSM state type for the correlator array and the
// disparity-selection stage that follows it.
package corr_pkg;

    localparam int NCORR      = 21;
    localparam int CORR_W     = 16;
    localparam int IDX_W      = 5;
    localparam int MIN_MARGIN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/peak_track.sv
// Combinational best/runner-up update for one correlation sample.
// The caller owns the registers; this only computes their next values.
module peak_track
    import corr_pkg::*;
(
    input  logic [CORR_W-1:0] v_i,
    input  logic [IDX_W-1:0]  cnt_i,
    input  logic [CORR_W-1:0] best_i,
    input  logic [CORR_W-1:0] second_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [CORR_W-1:0] best_o,
    output logic [CORR_W-1:0] second_o,
    output logic [IDX_W-1:0]  idx_o
);

    always_comb begin
        best_o   = best_i;
        second_o = second_i;
        idx_o    = idx_i;
        // Strict compare: an equal later lag never steals the index but does fill second.
        if (v_i > best_i) begin
            second_o = best_i;
            best_o   = v_i;
            idx_o    = cnt_i;
        end else if (v_i > second_i) begin
            second_o = v_i;
        end
    end

endmodule

// File: rtl/corr_peak_select.sv
// Disparity selection: snapshots all correlation lags on start, scans one lag
// per clock, then publishes winning lag, peak, runner-up and a confidence flag.
module corr_peak_select
    import corr_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NCORR*CORR_W-1:0] corr_in,
    output logic                    busy,
    output logic                    disp_valid,
    output logic [IDX_W-1:0]        disp_idx,
    output logic [CORR_W-1:0]       disp_peak,
    output logic [CORR_W-1:0]       disp_second,
    output logic                    disp_conf,
    output logic                    overrun,
    output logic [1:0]              dbg_state
);

    localparam logic [IDX_W-1:0] LAST_LAG = IDX_W'(NCORR - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [CORR_W-1:0] best_q, best_d;
    logic [CORR_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CORR_W-1:0] snap_q [NCORR];

    logic [CORR_W-1:0] pt_best, pt_second;
    logic [IDX_W-1:0]  pt_idx;
    logic [CORR_W-1:0] margin;
    logic              accept;

    assign accept    = (state_q == IDLE) && start;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign margin    = best_q - second_q;

    peak_track u_peak_track (
        .v_i      (snap_q[cnt_q]),
        .cnt_i    (cnt_q),
        .best_i   (best_q),
        .second_i (second_q),
        .idx_i    (idx_q),
        .best_o   (pt_best),
        .second_o (pt_second),
        .idx_o    (pt_idx)
    );

    // Snapshot carries no reset: it is only read after an accepting start reloads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NCORR; k++) begin
                snap_q[k] <= corr_in[k*CORR_W +: CORR_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    cnt_d    = '0;
                    best_d   = '0;
                    second_d = '0;
                    idx_d    = '0;
                end
            end
            SCAN: begin
                best_d   = pt_best;
                second_d = pt_second;
                idx_d    = pt_idx;
                cnt_d    = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_LAG) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            best_q   <= '0;
            second_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid  <= 1'b0;
            disp_idx    <= '0;
            disp_peak   <= '0;
            disp_second <= '0;
            disp_conf   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            if (state_q == DONE) begin
                disp_valid  <= 1'b1;
                disp_idx    <= idx_q;
                disp_peak   <= best_q;
                disp_second <= second_q;
                disp_conf   <= (margin >= CORR_W'(MIN_MARGIN));
            end
            if (start && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_corr_peak_select.sv
// Directed self-checking bench for corr_peak_select.
module tb_corr_peak_select;
    import corr_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [NCORR*CORR_W-1:0] corr_in;
    logic                    busy;
    logic                    disp_valid;
    logic [IDX_W-1:0]        disp_idx;
    logic [CORR_W-1:0]       disp_peak;
    logic [CORR_W-1:0]       disp_second;
    logic                    disp_conf;
    logic                    overrun;
    logic [1:0]              dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;

    corr_peak_select dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .corr_in     (corr_in),
        .busy        (busy),
        .disp_valid  (disp_valid),
        .disp_idx    (disp_idx),
        .disp_peak   (disp_peak),
        .disp_second (disp_second),
        .disp_conf   (disp_conf),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (disp_valid === 1'b1) n_valid++;
    end

    // ---------------- helpers
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCORR*CORR_W-1:0] vec_single();
        logic [NCORR*CORR_W-1:0] v;
        for (int k = 0; k < NCORR; k++) v[k*CORR_W +: CORR_W] = CORR_W'(k * 10);
        v[7*CORR_W +: CORR_W] = 16'd5000;
        return v;
    endfunction

    function automatic logic [NCORR*CORR_W-1:0] vec_tie();
        logic [NCORR*CORR_W-1:0] v;
        for (int k = 0; k < NCORR; k++) v[k*CORR_W +: CORR_W] = 16'd1;
        v[3*CORR_W +: CORR_W]  = 16'h8000;
        v[12*CORR_W +: CORR_W] = 16'h8000;
        return v;
    endfunction

    function automatic logic [NCORR*CORR_W-1:0] vec_top();
        logic [NCORR*CORR_W-1:0] v;
        v = '0;
        v[20*CORR_W +: CORR_W] = 16'hFFFF;
        return v;
    endfunction

    // Pulse start with data on one edge; data is then scrambled to prove it is not resampled.
    task automatic do_start(input logic [NCORR*CORR_W-1:0] data);
        start   = 1'b1;
        corr_in = data;
        tick();
        start   = 1'b0;
        corr_in = {NCORR{16'h7777}};
    endtask

    // Wait (bounded) for disp_valid; reports clocks since the start edge.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 60) begin
            if (lat > 0 || disp_valid !== 1'b1) begin
                tick();
                lat++;
            end
            if (disp_valid === 1'b1) seen = 1;
        end
        check({tag, ".seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, lat, exp_lat);
    endtask

    task automatic check_res(input string tag, input logic [IDX_W-1:0] idx,
                             input logic [CORR_W-1:0] peak, input logic [CORR_W-1:0] sec,
                             input logic conf);
        check({tag, ".idx"}, 32'(disp_idx), 32'(idx));
        check({tag, ".peak"}, 32'(disp_peak), 32'(peak));
        check({tag, ".second"}, 32'(disp_second), 32'(sec));
        check({tag, ".conf"}, 32'(disp_conf), 32'(conf));
    endtask

    // ---------------- stimulus
    initial begin
        int nv;
        rst     = 1'b1;
        start   = 1'b0;
        corr_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset.busy", 32'(busy), 32'd0);
        check("reset.valid", 32'(disp_valid), 32'd0);
        check("reset.overrun", 32'(overrun), 32'd0);
        check("reset.state", 32'(dbg_state), 32'd0);
        check_res("reset", 5'd0, 16'd0, 16'd0, 1'b0);

        // 1: single peak
        do_start(vec_single());
        check("t1.busy", 32'(busy), 32'd1);
        wait_valid("t1", 22);
        check_res("t1", 5'd7, 16'd5000, 16'd200, 1'b1);
        tick();
        check("t1.valid_pulse", 32'(disp_valid), 32'd0);
        check("t1.hold_peak", 32'(disp_peak), 32'd5000);
        check("t1.busy_after", 32'(busy), 32'd0);

        // 2: tie between lags 3 and 12
        do_start(vec_tie());
        wait_valid("t2", 22);
        check_res("t2", 5'd3, 16'h8000, 16'h8000, 1'b0);
        tick();

        // 3: boundary lag 20 at max, then all zero
        do_start(vec_top());
        wait_valid("t3a", 22);
        check_res("t3a", 5'd20, 16'hFFFF, 16'd0, 1'b1);
        tick();
        do_start('0);
        wait_valid("t3b", 22);
        check_res("t3b", 5'd0, 16'd0, 16'd0, 1'b0);
        tick();

        // 4: overrun
        nv = n_valid;
        do_start(vec_single());
        repeat (4) tick();
        do_start(vec_top());
        check("t4.overrun_set", 32'(overrun), 32'd1);
        wait_valid("t4", 17);
        check_res("t4", 5'd7, 16'd5000, 16'd200, 1'b1);
        repeat (30) tick();
        check("t4.one_valid", n_valid - nv, 32'd1);
        check("t4.overrun_sticky", 32'(overrun), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4.overrun_clr", 32'(overrun), 32'd0);
        tick();

        // 5: reset mid-scan (rst sampled on the 10th edge after start)
        do_start(vec_tie());
        nv = n_valid;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        check("t5.no_valid", n_valid - nv, 32'd0);
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.overrun", 32'(overrun), 32'd0);
        check_res("t5.cleared", 5'd0, 16'd0, 16'd0, 1'b0);
        do_start(vec_top());
        wait_valid("t5.fresh", 22);
        check_res("t5.fresh", 5'd20, 16'hFFFF, 16'd0, 1'b1);
        tick();

        // 6: back-to-back at cycles 0 and 23
        nv = n_valid;
        do_start(vec_single());
        wait_valid("t6a", 22);
        check_res("t6a", 5'd7, 16'd5000, 16'd200, 1'b1);
        do_start(vec_tie());
        check("t6.accept_busy", 32'(busy), 32'd1);
        wait_valid("t6b", 22);
        check_res("t6b", 5'd3, 16'h8000, 16'h8000, 1'b0);
        tick();
        check("t6.two_valid", n_valid - nv, 32'd2);
        check("t6.overrun", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
